// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I/RV64I base opcodes and the instruction format enum.
package decode_pkg;

  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] BRANCH    = 7'b1100011;
  localparam logic [6:0] LOAD      = 7'b0000011;
  localparam logic [6:0] STORE     = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP        = 7'b0110011;
  localparam logic [6:0] OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam logic [6:0] MISC_MEM  = 7'b0001111;
  localparam logic [6:0] SYSTEM    = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator: assembles the format-specific immediate
// and sign-extends it from inst[31] to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] w_imm32;
  logic               w_unused_opcode;

  // Opcode bits carry no immediate data in any format.
  assign w_unused_opcode = ^inst[6:0];

  always_comb begin
    w_imm32 = '0;
    unique case (fmt)
      FMT_I:   w_imm32 = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   w_imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   w_imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   w_imm32 = {inst[31:12], 12'b0};
      FMT_J:   w_imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  assign imm = XLEN'(w_imm32);

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready handshake and flush.
// Define DECODE_ILLEGAL_CHECK_EN to build the illegal-encoding detector.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [6:0]      w_funct7;
  fmt_e            w_fmt;
  logic [XLEN-1:0] w_imm;
  logic            w_capture;

  logic            r_valid;
  logic [PC_W-1:0] r_pc;
  logic [6:0]      r_opcode;
  logic [4:0]      r_rd;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [6:0]      r_funct7;
  logic [XLEN-1:0] r_imm;
  fmt_e            r_fmt;

  assign w_opcode = in_inst[6:0];
  assign w_rd     = in_inst[11:7];
  assign w_funct3 = in_inst[14:12];
  assign w_rs1    = in_inst[19:15];
  assign w_rs2    = in_inst[24:20];
  assign w_funct7 = in_inst[31:25];

  always_comb begin
    w_fmt = FMT_NONE;
    unique case (w_opcode)
      OP:                                      w_fmt = FMT_R;
      OP_32:                                   w_fmt = (XLEN == 64) ? FMT_R : FMT_NONE;
      OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM:    w_fmt = FMT_I;
      OP_IMM_32:                               w_fmt = (XLEN == 64) ? FMT_I : FMT_NONE;
      STORE:                                   w_fmt = FMT_S;
      BRANCH:                                  w_fmt = FMT_B;
      LUI, AUIPC:                              w_fmt = FMT_U;
      JAL:                                     w_fmt = FMT_J;
      default:                                 w_fmt = FMT_NONE;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst (in_inst),
    .fmt  (w_fmt),
    .imm  (w_imm)
  );

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  // Flush outranks capture; a capture outranks the plain handshake drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_opcode <= '0;
      r_rd     <= '0;
      r_funct3 <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_funct7 <= '0;
      r_imm    <= '0;
      r_fmt    <= FMT_R;
    end else if (flush) begin
      r_valid  <= 1'b0;
    end else if (w_capture) begin
      r_valid  <= 1'b1;
      r_pc     <= in_pc;
      r_opcode <= w_opcode;
      r_rd     <= w_rd;
      r_funct3 <= w_funct3;
      r_rs1    <= w_rs1;
      r_rs2    <= w_rs2;
      r_funct7 <= w_funct7;
      r_imm    <= w_imm;
      r_fmt    <= w_fmt;
    end else if (out_ready) begin
      r_valid  <= 1'b0;
    end
  end

`ifdef DECODE_ILLEGAL_CHECK_EN
  logic w_illegal;
  logic r_illegal;

  always_comb begin
    w_illegal = 1'b0;
    if (in_inst[1:0] != 2'b11)                                      w_illegal = 1'b1;
    if (w_fmt == FMT_NONE)                                          w_illegal = 1'b1;
    if ((w_opcode == JALR) && (w_funct3 != 3'b000))                 w_illegal = 1'b1;
    if ((w_opcode == BRANCH) && (w_funct3[2:1] == 2'b01))           w_illegal = 1'b1;
    if ((w_opcode == OP) && (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000))
                                                                    w_illegal = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_illegal <= 1'b0;
    else if (w_capture && !flush) r_illegal <= w_illegal;
  end

  assign illegal = r_illegal;
`else
  assign illegal = 1'b0;
`endif

  assign out_valid = r_valid;
  assign out_pc    = r_pc;
  assign opcode    = r_opcode;
  assign rd        = r_rd;
  assign funct3    = r_funct3;
  assign rs1       = r_rs1;
  assign rs2       = r_rs2;
  assign funct7    = r_funct7;
  assign imm       = r_imm;
  assign fmt       = r_fmt;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (XLEN=32); illegal expectations
// follow DECODE_ILLEGAL_CHECK_EN.
module tb_decode_stage;

  localparam int XLEN = 32;
  localparam int PC_W = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;

  int unsigned n_cmp;
  int unsigned n_err;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_NONE = 3'd6;

  decode_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .opcode    (opcode),
    .rd        (rd),
    .funct3    (funct3),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct7    (funct7),
    .imm       (imm),
    .fmt       (fmt),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_imm",       64'(imm),       64'd0);
    chk("rst_pc",        64'(out_pc),    64'd0);
    step();
    rst = 1'b0;

    // addi x1,x0,-1
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 32'h100;
    step();
    chk("addi_valid",  64'(out_valid), 64'd1);
    chk("addi_opcode", 64'(opcode),    64'h13);
    chk("addi_rd",     64'(rd),        64'd1);
    chk("addi_rs1",    64'(rs1),       64'd0);
    chk("addi_fmt",    64'(fmt),       64'(F_I));
    chk("addi_imm",    64'(imm),       64'hFFFFFFFF);
    chk("addi_pc",     64'(out_pc),    64'h100);
    chk("addi_ill",    64'(illegal),   64'd0);

    // sw x2,8(x1) back-to-back
    in_inst = 32'h0020A423; in_pc = 32'h104;
    step();
    chk("sw_valid",  64'(out_valid), 64'd1);
    chk("sw_fmt",    64'(fmt),       64'(F_S));
    chk("sw_rs1",    64'(rs1),       64'd1);
    chk("sw_rs2",    64'(rs2),       64'd2);
    chk("sw_funct3", 64'(funct3),    64'd2);
    chk("sw_imm",    64'(imm),       64'd8);
    chk("sw_pc",     64'(out_pc),    64'h104);

    // beq x0,x0,-4
    in_inst = 32'hFE000EE3; in_pc = 32'h108;
    step();
    chk("beq_valid", 64'(out_valid), 64'd1);
    chk("beq_fmt",   64'(fmt),       64'(F_B));
    chk("beq_imm",   64'(imm),       64'hFFFFFFFC);
    chk("beq_f7",    64'(funct7),    64'h7F);

    // lui x5,0x12345
    in_inst = 32'h123452B7; in_pc = 32'h10C;
    step();
    chk("lui_valid", 64'(out_valid), 64'd1);
    chk("lui_fmt",   64'(fmt),       64'(F_U));
    chk("lui_rd",    64'(rd),        64'd5);
    chk("lui_imm",   64'(imm),       64'h12345000);
    chk("lui_pc",    64'(out_pc),    64'h10C);

    in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);

    // Backpressure: addi x2,x0,5 captured, then jal x1,8 waits
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00500113; in_pc = 32'h200;
    step();
    chk("bp_cap_valid", 64'(out_valid), 64'd1);
    chk("bp_cap_imm",   64'(imm),       64'd5);
    in_inst = 32'h008000EF; in_pc = 32'h204;
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_pc",    64'(out_pc),    64'h200);
      chk("bp_hold_imm",   64'(imm),       64'd5);
      chk("bp_hold_rd",    64'(rd),        64'd2);
      chk("bp_hold_rdy",   64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rel_ready", 64'(in_ready), 64'd1);
    step();
    chk("jal_valid", 64'(out_valid), 64'd1);
    chk("jal_fmt",   64'(fmt),       64'(F_J));
    chk("jal_imm",   64'(imm),       64'd8);
    chk("jal_rd",    64'(rd),        64'd1);
    chk("jal_pc",    64'(out_pc),    64'h204);

    // Flush with out_valid=1 and in_valid=1
    flush = 1'b1; in_inst = 32'h00000033; in_pc = 32'h300;
    #1;
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    step();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_nocap", 64'(out_pc),    64'h204);
    flush = 1'b0; in_valid = 1'b0;
    step();
    chk("fl_idle", 64'(out_valid), 64'd0);

    // Encodings for the illegal detector and format edges
    in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 32'h400;
    step();
    chk("zero_fmt", 64'(fmt),     64'(F_NONE));
    chk("zero_imm", 64'(imm),     64'd0);
    chk("zero_ill", 64'(illegal), 64'(ILL_EXP));
    in_inst = 32'h00001067; in_pc = 32'h404;
    step();
    chk("jalr_fmt",    64'(fmt),     64'(F_I));
    chk("jalr_funct3", 64'(funct3),  64'd1);
    chk("jalr_ill",    64'(illegal), 64'(ILL_EXP));
    in_inst = 32'h40000033; in_pc = 32'h408;
    step();
    chk("sub_fmt", 64'(fmt),     64'(F_R));
    chk("sub_f7",  64'(funct7),  64'h20);
    chk("sub_imm", 64'(imm),     64'd0);
    chk("sub_ill", 64'(illegal), 64'd0);
    in_inst = 32'h0000003B; in_pc = 32'h40C;
    step();
    chk("op32_fmt", 64'(fmt), 64'(F_NONE));

    // Asynchronous reset mid-stream
    in_inst = 32'hFFF00093; in_pc = 32'h500;
    step();
    chk("pre_rst_imm", 64'(imm), 64'hFFFFFFFF);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid",  64'(out_valid), 64'd0);
    chk("arst_imm",    64'(imm),       64'd0);
    chk("arst_opcode", 64'(opcode),    64'd0);
    chk("arst_ready",  64'(in_ready),  64'd1);
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
